// File: rtl/gf2_matvec_seq.sv
// Sequential N x N matrix-vector multiplier over GF(2). The matrix lives in a
// row-addressable register file; each input vector produces one result row per cycle.
module gf2_matvec_seq #(
    parameter  int N  = 4,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          row_wr_en,
    input  logic [AW-1:0] row_wr_addr,
    input  logic [N-1:0]  row_wr_data,
    input  logic          vec_valid,
    output logic          vec_ready,
    input  logic [N-1:0]  vec_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;

    state_e        state_q, state_d;
    logic          live_q;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [N-1:0]  out_q, out_d;
    logic [N-1:0]  a_q [N];
    logic          accept;
    logic          last_row;

    assign accept   = vec_valid & vec_ready;
    assign last_row = (cnt_q == AW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept)    state_d = S_COMPUTE;
            S_COMPUTE: if (last_row)  state_d = S_DONE;
            S_DONE:    if (out_ready) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // vec_ready is held off until the first edge after reset release
    always_comb begin
        vec_ready = (state_q == S_IDLE) && live_q;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out_data  = out_q;
    end

    always_comb begin
        vec_d = vec_q;
        cnt_d = cnt_q;
        out_d = out_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vec_d = vec_data;
                    out_d = '0;
                    cnt_d = '0;
                end
            end
            S_COMPUTE: begin
                out_d[cnt_q] = ^(a_q[cnt_q] & vec_q);
                cnt_d        = last_row ? '0 : cnt_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            cnt_q  <= '0;
            vec_q  <= '0;
            out_q  <= '0;
        end else begin
            live_q <= 1'b1;
            cnt_q  <= cnt_d;
            vec_q  <= vec_d;
            out_q  <= out_d;
        end
    end

    // Rows are only writable in IDLE so A is frozen for a whole computation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) a_q[i] <= '0;
        end else if (row_wr_en && state_q == S_IDLE && int'(row_wr_addr) < N) begin
            a_q[row_wr_addr] <= row_wr_data;
        end
    end

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// Self-checking bench for gf2_matvec_seq: table vectors, random vectors against a
// parity-based matrix model, and directed handshake/reset corner cases (N=4 and N=1).
module tb_gf2_matvec_seq;
    localparam int N = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       row_wr_en;
    logic [1:0] row_wr_addr;
    logic [3:0] row_wr_data;
    logic       vec_valid;
    logic       vec_ready;
    logic [3:0] vec_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    logic       n1_wr_en, n1_vec_valid, n1_vec_ready, n1_out_valid, n1_out_ready, n1_busy;
    logic [0:0] n1_wr_addr, n1_wr_data, n1_vec_data, n1_out_data;

    gf2_matvec_seq #(.N(4)) dut (
        .clk(clk), .rst(rst),
        .row_wr_en(row_wr_en), .row_wr_addr(row_wr_addr), .row_wr_data(row_wr_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    gf2_matvec_seq #(.N(1)) dut1 (
        .clk(clk), .rst(rst),
        .row_wr_en(n1_wr_en), .row_wr_addr(n1_wr_addr), .row_wr_data(n1_wr_data),
        .vec_valid(n1_vec_valid), .vec_ready(n1_vec_ready), .vec_data(n1_vec_data),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_data(n1_out_data),
        .busy(n1_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] mdl [4];

    typedef struct {
        logic [15:0] rows;
        logic [3:0]  v;
        logic [3:0]  exp;
    } vec_t;
    vec_t tbl [5];

    // u_r is the parity of the number of positions where row r and v are both 1
    function automatic logic [3:0] model_mul(logic [3:0] v);
        logic [3:0] u;
        for (int r = 0; r < 4; r++) u[r] = ($countones(mdl[r] & v) % 2) == 1;
        return u;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_row(int r, logic [3:0] d);
        row_wr_en   = 1'b1;
        row_wr_addr = r[1:0];
        row_wr_data = d;
        tick();
        row_wr_en = 1'b0;
        mdl[r] = d;
    endtask

    task automatic start_vec(logic [3:0] v, output int t_hs);
        int k = 0;
        while (!vec_ready && k < 20) begin tick(); k++; end
        check("vec_ready_wait", vec_ready, 1);
        vec_valid = 1'b1;
        vec_data  = v;
        tick();
        t_hs = cyc;
        vec_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic run_vec(logic [3:0] v, output logic [3:0] got, output int t_hs);
        int lat;
        start_vec(v, t_hs);
        wait_done(lat);
        check("latency", lat, N);
        check("result", out_data, model_mul(v));
        got = out_data;
        tick();
        check("release_valid", out_valid, 0);
        check("release_ready", vec_ready, 1);
    endtask

    initial begin
        logic [3:0] got, v, snap;
        int t0, t1, t2, lat;

        tbl[0] = '{rows: 16'h8421, v: 4'b1011, exp: 4'b1011};
        tbl[1] = '{rows: 16'h0F63, v: 4'b0101, exp: 4'b0011};
        tbl[2] = '{rows: 16'hFFFF, v: 4'b0111, exp: 4'b1111};
        tbl[3] = '{rows: 16'h8888, v: 4'b1100, exp: 4'b1111};
        tbl[4] = '{rows: 16'h8888, v: 4'b0111, exp: 4'b0000};

        rst = 1'b1;
        row_wr_en = 0; row_wr_addr = 0; row_wr_data = 0;
        vec_valid = 0; vec_data = 0; out_ready = 1'b1;
        n1_wr_en = 0; n1_wr_addr = 0; n1_wr_data = 0;
        n1_vec_valid = 0; n1_vec_data = 0; n1_out_ready = 1'b1;
        for (int r = 0; r < 4; r++) mdl[r] = '0;

        #2;
        check("rst_vec_ready", vec_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("post_rst_ready_low", vec_ready, 0);
        tick();
        check("post_rst_ready_high", vec_ready, 1);
        // all-zero matrix after reset
        run_vec(4'hF, got, t0);
        check("zero_matrix", got, 4'h0);

        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < 4; r++) wr_row(r, tbl[i].rows[4*r +: 4]);
            run_vec(tbl[i].v, got, t0);
            check($sformatf("table_%0d", i), got, tbl[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            wr_row($urandom_range(0, 3), 4'($urandom));
            run_vec(4'($urandom), got, t0);
        end

        // row write during COMPUTE is dropped
        v = 4'b1101;
        start_vec(v, t0);
        row_wr_en = 1'b1; row_wr_addr = 2'd2; row_wr_data = ~mdl[2];
        tick();
        row_wr_en = 1'b0;
        wait_done(lat);
        check("lock_first", out_data, model_mul(v));
        tick();
        run_vec(v, got, t0);
        check("lock_recompute", got, model_mul(v));

        // row write and handshake on the same edge
        for (int r = 0; r < 4; r++) wr_row(r, 4'b0000);
        row_wr_en = 1'b1; row_wr_addr = 2'd0; row_wr_data = 4'b0001;
        vec_valid = 1'b1; vec_data = 4'b0001;
        tick();
        row_wr_en = 1'b0; vec_valid = 1'b0;
        mdl[0] = 4'b0001;
        wait_done(lat);
        check("same_edge_u0", out_data[0], 1);
        check("same_edge_all", out_data, model_mul(4'b0001));
        tick();

        // backpressure in DONE
        for (int r = 0; r < 4; r++) wr_row(r, 4'($urandom));
        out_ready = 1'b0;
        v = 4'b1010;
        start_vec(v, t0);
        wait_done(lat);
        check("bp_latency", lat, N);
        check("bp_result", out_data, model_mul(v));
        snap = out_data;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin vec_valid = 1'b1; vec_data = ~v; end
            if (i == 5) begin row_wr_en = 1'b1; row_wr_addr = 2'd1; row_wr_data = ~mdl[1]; end
            tick();
            vec_valid = 1'b0; row_wr_en = 1'b0;
            check("bp_hold_data", out_data, snap);
            check("bp_hold_valid", out_valid, 1);
            check("bp_ready_low", vec_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", vec_ready, 1);
        check("bp_release_busy", busy, 0);
        tick(); tick();
        check("bp_nothing_queued", out_valid, 0);
        run_vec(v, got, t0);
        check("bp_matrix_kept", got, snap);

        // reset two cycles into COMPUTE
        start_vec(4'hF, t0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", vec_ready, 0);
        check("mid_rst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < 4; r++) mdl[r] = '0;
        run_vec(4'hF, got, t0);
        check("post_rst_zero", got, 4'h0);

        // back-to-back throughput with out_ready high
        for (int r = 0; r < 4; r++) wr_row(r, 4'($urandom));
        run_vec(4'($urandom), got, t0);
        run_vec(4'($urandom), got, t1);
        run_vec(4'($urandom), got, t2);
        check("b2b_gap1", t1 - t0, N + 2);
        check("b2b_gap2", t2 - t1, N + 2);

        // N=1 instance
        n1_wr_en = 1'b1; n1_wr_data = 1'b1;
        tick();
        n1_wr_en = 1'b0;
        check("n1_ready", n1_vec_ready, 1);
        n1_vec_valid = 1'b1; n1_vec_data = 1'b1;
        tick();
        n1_vec_valid = 1'b0;
        check("n1_compute", n1_out_valid, 0);
        check("n1_busy", n1_busy, 1);
        tick();
        check("n1_valid", n1_out_valid, 1);
        check("n1_data_1", n1_out_data, 1);
        tick();
        check("n1_release", n1_out_valid, 0);
        n1_vec_valid = 1'b1; n1_vec_data = 1'b0;
        tick();
        n1_vec_valid = 1'b0;
        tick();
        check("n1_valid_2", n1_out_valid, 1);
        check("n1_data_0", n1_out_data, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
